// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order requests at the current PC and queues
// returned instructions with their PCs for decode. Redirects flush the queue.
module fetch_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg, nfill_reg, drop_reg;

  logic             fire, pop, rsp_drop, rsp_fill, room;
  logic [PTR_W-1:0] fill_ptr;
  logic [CNT_W:0]   drop_next;

  // Responses return in order, so filled entries are always the oldest ones:
  // a fill count from head replaces per-entry filled flags.
  assign fill_ptr = head_reg + PTR_W'(nfill_reg);
  assign room     = ({1'b0, count_reg} + {1'b0, drop_reg}) < DEPTH_C;

  assign imem_req_valid = res & ~redirect_valid & room;
  assign imem_req_addr  = pc_in;
  assign fire           = imem_req_valid & imem_req_ready;

  assign if_valid = res & ~redirect_valid & (count_reg != '0) & (nfill_reg != '0);
  assign if_instr = instr_q[head_reg];
  assign if_pc    = pc_q[head_reg];
  assign pop      = if_valid & id_ready;

  assign rsp_drop = imem_rsp_valid & (drop_reg != '0);
  assign rsp_fill = imem_rsp_valid & (drop_reg == '0) & (nfill_reg < count_reg);

  assign pc_write = res & (redirect_valid | fire);

  always_comb begin
    pc_next = '0;
    if (res) begin
      if (redirect_valid) pc_next = {redirect_target[31:2], 2'b00};
      else                pc_next = pc_in + 32'd4;
    end
  end

  // On a flush every still-unfilled entry becomes a response to discard; a
  // response arriving in the same cycle already accounts for one of them.
  always_comb begin
    drop_next = {1'b0, drop_reg} + {1'b0, count_reg - nfill_reg};
    if (imem_rsp_valid && drop_next != '0)
      drop_next = drop_next - (CNT_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      nfill_reg <= '0;
      drop_reg  <= '0;
    end else if (redirect_valid) begin
      head_reg  <= tail_reg;
      count_reg <= '0;
      nfill_reg <= '0;
      drop_reg  <= CNT_W'(drop_next);
    end else begin
      tail_reg  <= tail_reg + PTR_W'(fire);
      head_reg  <= head_reg + PTR_W'(pop);
      count_reg <= count_reg + CNT_W'(fire) - CNT_W'(pop);
      nfill_reg <= nfill_reg + CNT_W'(rsp_fill) - CNT_W'(pop);
      drop_reg  <= drop_reg - CNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      if (fire)     pc_q[tail_reg]    <= pc_in;
      if (rsp_fill) instr_q[fill_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and memory models, cycle table plus
// hand-written redirect/reset sequences, scoreboard on every decode pop.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b1;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .pc_in(pc_in), .pc_next(pc_next), .pc_write(pc_write),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        id_rdy;
    logic        mem_rdy;
    logic        exp_rv;
    logic        exp_pw;
    logic        exp_iv;
    logic [31:0] exp_addr;
    logic [31:0] exp_pn;
    logic [31:0] exp_ipc;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [31:0] pend[$];
  logic        mem_hold = 1'b0;
  logic [31:0] pc_rst = '0;
  logic        s_fire, s_pw;
  logic [31:0] s_addr, s_pn;
  vec_t        tbl[17];

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge: scoreboard bookkeeping, then the clock edge and
  // the PC-register / 1-cycle-memory models update their inputs.
  task automatic end_cycle();
    if (res) begin
      if (if_valid && id_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: popped pc %h, nothing expected", if_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pc", if_pc, e.pc);
          chk("sb_instr", if_instr, e.instr);
        end
      end
      if (redirect_valid) sb.delete();
      if (imem_req_valid && imem_req_ready) sb.push_back('{pc_in, imem_word(pc_in)});
    end
    s_fire = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_pw   = pc_write;
    s_pn   = pc_next;
    @(posedge clk);
    #1;
    if (!res) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      pc_in = pc_rst;
    end else begin
      if (s_pw) pc_in = s_pn;
      if (s_fire) pend.push_back(s_addr);
      if (!mem_hold && pend.size() > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = imem_word(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    end_cycle();
  endtask

  task automatic do_reset(input logic [31:0] start, input int cycles);
    res = 1'b0;
    pc_rst = start;
    pc_in = start;
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    imem_rsp_valid = 1'b0;
    pend.delete();
    sb.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_pc_next", pc_next, 32'd0);
      end_cycle();
    end
    res = 1'b1;
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (if_valid) begin
        chk(name, if_pc, exp_pc);
        found = 1'b1;
      end
      end_cycle();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: if_valid never rose in 10 cycles, expected pc %h", name, exp_pc);
    end
  endtask

  initial begin
    //              id    mem   rv    pw    iv    addr          pc_next       if_pc
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 32'h04, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h04, 32'h08, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h08, 32'h0C, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 32'h0C, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0C, 32'h10, 32'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h14, 32'h08};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h14, 32'h0C};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h18, 32'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h18, 32'h1C, 32'h10};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h18, 32'h1C, 32'h10};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h18, 32'h1C, 32'h10};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 32'h1C, 32'h14};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C, 32'h20, 32'h00};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1C, 32'h20, 32'h18};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C, 32'h20, 32'h00};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C, 32'h20, 32'h00};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1C, 32'h20, 32'h00};

    // Streaming, decode backpressure and memory stall from PC 0.
    do_reset(32'h0, 3);
    for (int i = 0; i < 17; i++) begin
      id_ready = tbl[i].id_rdy;
      imem_req_ready = tbl[i].mem_rdy;
      @(negedge clk);
      chk($sformatf("t%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].exp_rv});
      chk($sformatf("t%0d_pc_write", i), {31'd0, pc_write}, {31'd0, tbl[i].exp_pw});
      chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      if (tbl[i].exp_pw) chk($sformatf("t%0d_pc_next", i), pc_next, tbl[i].exp_pn);
      chk($sformatf("t%0d_if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) chk($sformatf("t%0d_if_pc", i), if_pc, tbl[i].exp_ipc);
      end_cycle();
    end

    // Redirect with two requests still unanswered: both responses must be dropped.
    do_reset(32'h40, 3);
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    mem_hold = 1'b1;
    @(negedge clk);
    chk("r1_fire0", {31'd0, imem_req_valid}, 32'd1);
    end_cycle();
    @(negedge clk);
    chk("r1_fire1", imem_req_addr, 32'h44);
    end_cycle();
    redirect_valid = 1'b1;
    redirect_target = 32'h103;
    @(negedge clk);
    chk("r1_pc_write", {31'd0, pc_write}, 32'd1);
    chk("r1_pc_next", pc_next, 32'h100);
    chk("r1_if_valid", {31'd0, if_valid}, 32'd0);
    chk("r1_req_blocked", {31'd0, imem_req_valid}, 32'd0);
    mem_hold = 1'b0;
    end_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("r1_drop2_blocks", {31'd0, imem_req_valid}, 32'd0);
    end_cycle();
    @(negedge clk);
    chk("r1_drop1_issue", {31'd0, imem_req_valid}, 32'd1);
    chk("r1_issue_addr", imem_req_addr, 32'h100);
    end_cycle();
    wait_first("r1_first_pc", 32'h100);

    // Redirect coinciding with the only outstanding response: nothing left to drop.
    do_reset(32'h80, 3);
    id_ready = 1'b1;
    @(negedge clk);
    chk("r2_fire", imem_req_addr, 32'h80);
    end_cycle();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    @(negedge clk);
    chk("r2_pc_next", pc_next, 32'h100);
    chk("r2_req_blocked", {31'd0, imem_req_valid}, 32'd0);
    end_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("r2_no_drop_issue", {31'd0, imem_req_valid}, 32'd1);
    chk("r2_issue_addr", imem_req_addr, 32'h100);
    end_cycle();
    wait_first("r2_first_pc", 32'h100);

    // Asynchronous reset with two filled entries queued.
    do_reset(32'h200, 3);
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("ar_pre_if_valid", {31'd0, if_valid}, 32'd1);
    chk("ar_pre_if_pc", if_pc, 32'h200);
    end_cycle();
    #2;
    res = 1'b0;
    #1;
    chk("ar_if_valid", {31'd0, if_valid}, 32'd0);
    chk("ar_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("ar_pc_write", {31'd0, pc_write}, 32'd0);
    do_reset(32'h300, 3);
    id_ready = 1'b1;
    @(negedge clk);
    chk("ar_restart_addr", imem_req_addr, 32'h300);
    end_cycle();
    wait_first("ar_first_pc", 32'h300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
